// File: rtl/fsm_0101_detector.sv
// Serial "0101" detector, Mealy FSM with a selectable overlap mode; latency 0 cycles (Mealy) or 1 cycle with FSM_0101_REG_OUT_EN.
// No backpressure: one bit is consumed on every rising Clk while rst is high.
module fsm_0101_detector #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       In,
  output logic [1:0] state,
  output logic       Out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   hit;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S0;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S0: nxt_state = In ? S0 : S1;
      S1: nxt_state = In ? S2 : S1;
      S2: nxt_state = In ? S0 : S3;
      S3: begin
        if (!In) begin
          nxt_state = S1;
        end else begin
          // A completed match leaves "01" as the overlapping prefix.
          nxt_state = OVERLAP ? S2 : S0;
        end
      end
      default: nxt_state = S0;
    endcase
  end

  assign hit   = (cur_state == S3) && In;
  assign state = cur_state;

`ifdef FSM_0101_REG_OUT_EN
  logic out_q;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= hit;
    end
  end

  assign Out = out_q;
`else
  assign Out = hit && rst;
`endif

endmodule

// File: tb/tb_fsm_0101_detector.sv
// Randomised scoreboard bench for fsm_0101_detector, overlap and non-overlap instances side by side.
module tb_fsm_0101_detector;

  logic       clk;
  logic       rst;
  logic       din;
  logic [1:0] state_ov;
  logic [1:0] state_no;
  logic       out_ov;
  logic       out_no;

  int tests;
  int fails;
  bit drv_done;

  typedef struct {
    logic [1:0] st_ov;
    logic [1:0] st_no;
    logic       o_ov;
    logic       o_no;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: bit history since reset (and, without overlap, since the last hit).
  bit hist_ov[$];
  bit hist_no[$];
  bit prev_hit_ov;
  bit prev_hit_no;

  fsm_0101_detector #(.OVERLAP(1'b1)) u_ov (
    .Clk(clk), .rst(rst), .In(din), .state(state_ov), .Out(out_ov)
  );

  fsm_0101_detector #(.OVERLAP(1'b0)) u_no (
    .Clk(clk), .rst(rst), .In(din), .state(state_no), .Out(out_no)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic bit pat_bit(input int i);
    return (i % 2) == 1;
  endfunction

  function automatic bit ends_match(input bit h[$]);
    if (h.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (h[h.size() - 4 + i] != pat_bit(i)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Length of the longest history suffix that is a proper prefix of "0101".
  function automatic logic [1:0] prefix_len(input bit h[$]);
    for (int k = 3; k >= 1; k--) begin
      bit ok;
      ok = (h.size() >= k);
      for (int i = 0; i < k && ok; i++) begin
        if (h[h.size() - k + i] != pat_bit(i)) ok = 1'b0;
      end
      if (ok) return 2'(k);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    hist_ov.delete();
    hist_no.delete();
    prev_hit_ov = 1'b0;
    prev_hit_no = 1'b0;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_bit(input bit b);
    exp_t e;
    bit hit_ov;
    bit hit_no;
    @(negedge clk);
    #1;
    din = b;
    e.st_ov = prefix_len(hist_ov);
    e.st_no = prefix_len(hist_no);
    hist_ov.push_back(b);
    hist_no.push_back(b);
    hit_ov = ends_match(hist_ov);
    hit_no = ends_match(hist_no);
`ifdef FSM_0101_REG_OUT_EN
    e.o_ov = prev_hit_ov;
    e.o_no = prev_hit_no;
`else
    e.o_ov = hit_ov;
    e.o_no = hit_no;
`endif
    prev_hit_ov = hit_ov;
    prev_hit_no = hit_no;
    if (hist_ov.size() > 4) void'(hist_ov.pop_front());
    if (hit_no) hist_no.delete();
    else if (hist_no.size() > 4) void'(hist_no.pop_front());
    exp_q.push_back(e);
  endtask

  // Assert reset mid-cycle after the monitor has sampled, check the asynchronous clear.
  task automatic mid_reset();
    #6;
    rst = 1'b0;
    #1;
    check("rst_state_ov", state_ov, 2'b00);
    check("rst_state_no", state_no, 2'b00);
    check("rst_out_ov", {1'b0, out_ov}, 2'b00);
    check("rst_out_no", {1'b0, out_no}, 2'b00);
    model_reset();
    #5;
    rst = 1'b1;
  endtask

  task automatic drive_seq(input bit seq[$]);
    foreach (seq[i]) drive_bit(seq[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #5;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state_ov", state_ov, e.st_ov);
        check("state_no", state_no, e.st_no);
        check("out_ov", {1'b0, out_ov}, {1'b0, e.o_ov});
        check("out_no", {1'b0, out_no}, {1'b0, e.o_no});
      end
    end
  end

  initial begin : driver
    bit s2[$] = '{0, 0, 0, 1, 0, 1, 0};
    bit s3[$] = '{0, 1, 0, 1, 0, 1};
    bit s4[$] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0};
    bit s5[$] = '{0, 1, 0, 1};
    tests = 0;
    fails = 0;
    drv_done = 1'b0;
    rst = 1'b1;
    din = 1'b0;
    model_reset();

    #3;
    rst = 1'b0;
    #1;
    check("init_state_ov", state_ov, 2'b00);
    check("init_state_no", state_no, 2'b00);
    check("init_out_ov", {1'b0, out_ov}, 2'b00);
    check("init_out_no", {1'b0, out_no}, 2'b00);
    #9;
    rst = 1'b1;

    drive_seq(s2);
    drive_bit(1'b0);
    mid_reset();
    drive_seq(s3);
    drive_bit(1'b1);
    mid_reset();
    drive_seq(s4);
    mid_reset();
    // Reach "010", then reset while In=1 is presented to the overlap instance in S3.
    drive_seq(s5[0:2]);
    drive_bit(1'b1);
    mid_reset();
    drive_bit(1'b1);
    drive_bit(1'b1);

    for (int n = 0; n < 600; n++) begin
      // Bias towards 0101-rich streams so hits and overlaps are frequent.
      if ($urandom_range(0, 3) == 0) drive_bit(1'($urandom_range(0, 1)));
      else drive_bit(pat_bit(n));
      if ($urandom_range(0, 40) == 0) mid_reset();
    end
    drive_bit(1'b0);
    drv_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (drv_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
